td4_core: RTL and testbench
===========================

Name: td4_core

Overview:
- 4-bit TD4 CPU core that reads 8-bit instructions from the program ROM through a combinational address/data interface.
- Holds registers A, B, OUT, PC and the carry flag, and executes one instruction every two enabled cycles (FETCH, then EXEC).
- Sits between the program ROM and the board I/O (4 input switches, 4 output LEDs).
- Provides a step enable for slow or single-step clocking and a sticky halt indication.

Parameters:
- RESET_PC, 4'h0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  step enable; when low, all state holds.
- rom_addr  output  4  instruction address; equals PC at all times.
- rom_data  input  8  instruction from ROM; [7:4] opcode, [3:0] immediate.
- in_port  input  4  input switches; sampled in EXEC only.
- out_port  output  4  OUT register.
- fetch  output  1  high while state is FETCH.
- carry  output  1  carry flag.
- halted  output  1  sticky: a taken jump targeted its own address.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: PC=RESET_PC, A=0, B=0, OUT=0, IR=0, carry=0, halted=0, state=FETCH.
- rst has priority over en. Asserting rst mid-instruction discards the latched IR; the next cycle is FETCH at RESET_PC.
- State machine states: FETCH, EXEC.
  - FETCH, en=1: IR<=rom_data; go to EXEC.
  - EXEC, en=1: execute IR; go to FETCH.
  - en=0 in either state: no state or register change.
- Latency: 2 enabled cycles per instruction. Register results are visible the cycle after EXEC.
- Opcodes (im = IR[3:0]); all 4-bit arithmetic is modulo 16:
  - 0000 ADD A,im: {carry,A}<=A+im.
  - 0101 ADD B,im: {carry,B}<=B+im.
  - 0011 MOV A,im: A<=im.
  - 0111 MOV B,im: B<=im.
  - 0001 MOV A,B: A<=B.
  - 0100 MOV B,A: B<=A.
  - 0010 IN A: A<=in_port.
  - 0110 IN B: B<=in_port.
  - 1001 OUT B: OUT<=B.
  - 1011 OUT im: OUT<=im.
  - 1111 JMP im: PC<=im.
  - 1110 JNC im: PC<=im if carry==0, else PC+1.
  - 1000, 1010, 1100, 1101: NOP.
- Carry rule: every EXEC writes carry. ADD ops write the adder carry-out; all other ops, including NOP and JNC, write 0. JNC tests the carry value from before the EXEC edge.
- PC: in EXEC, PC<=PC+1 unless a jump is taken. PC wraps 4'hF -> 4'h0.
- Halt: halted<=1 when a taken JMP/JNC has target == current PC.
  - After halt, the core stays in FETCH and ignores en; registers freeze.
  - Only rst clears halted.
- Unspecified ROM contents read as 8'h00 (ADD A,0). This is legal and clears carry.

Decomposition:
- Package td4_pkg:
  - opcode enum (OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_A, OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_B, OP_OUT_B, OP_OUT_IM, OP_JNC, OP_JMP).
  - state enum (ST_FETCH, ST_EXEC).
  - constants DATA_W=4, INSTR_W=8.
- One sub-module, td4_alu: 4-bit adder with the operand mux (A, B, im, in_port, 0) and carry-out. The core keeps the FSM, register file and PC logic.

Test Plan:
- Reset/hold: assert rst with en=1 for 2 cycles -> PC=0, A=B=OUT=0, carry=0, fetch=1, halted=0. Then en=0 for 5 cycles -> no register or PC change.
- Arithmetic and carry: ROM 0:8'h33 (MOV A,3), 1:8'h0E (ADD A,14), 2:8'hE0 (JNC 0), 3:8'h01 (MOV A,B) -> after addr1 A=1, carry=1. JNC not taken, PC=3. After addr3 A=0, carry=0.
- I/O path: in_port=4'hA; ROM 0:8'h60 (IN B), 1:8'h90 (OUT B), 2:8'hB5 (OUT 5) -> out_port=A after 4 enabled cycles, 5 after 6. The in_port change during FETCH is ignored.
- PC wrap: ROM all 8'h00 -> PC steps 0..15 then 0. A stays 0, carry stays 0.
- Halt: ROM 0:8'h72 (MOV B,2), 1:8'hF1 (JMP 1) -> halted=1 after 4 enabled cycles. PC stays 1 and B stays 2 for 20 more cycles. rst clears halted.
- Reset mid-instruction: assert rst during EXEC of 8'h3F -> A stays 0, next state FETCH at PC=0.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 4-bit CPU core.
package td4_pkg;
  localparam int DATA_W  = 4;
  localparam int INSTR_W = 8;

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_A  = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_B  = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_IM = 4'b1011,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } op_e;

  typedef enum logic {ST_FETCH, ST_EXEC} state_e;

  typedef enum logic [2:0] {SRC_A, SRC_B, SRC_IM, SRC_IN, SRC_ZERO} src_e;
endpackage

// File: rtl/td4_alu.sv
// Operand mux plus 4-bit adder; moves are expressed as "operand + 0".
module td4_alu
  import td4_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] im,
  input  logic [DATA_W-1:0] in_port,
  input  src_e              src,
  input  logic              add_im,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);
  logic [DATA_W-1:0] opnd;

  always_comb begin
    opnd = '0;
    case (src)
      SRC_A:   opnd = a;
      SRC_B:   opnd = b;
      SRC_IM:  opnd = im;
      SRC_IN:  opnd = in_port;
      default: opnd = '0;
    endcase
    {cout, sum} = {1'b0, opnd} + {1'b0, (add_im ? im : {DATA_W{1'b0}})};
  end
endmodule

// File: rtl/td4_core.sv
// TD4 core: two-phase FETCH/EXEC sequencer, A/B/OUT registers, PC and carry.
module td4_core
  import td4_pkg::*;
#(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [DATA_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic [DATA_W-1:0]  in_port,
  output logic [DATA_W-1:0]  out_port,
  output logic               fetch,
  output logic               carry,
  output logic               halted
);
  state_e              state_q, state_d;
  logic [DATA_W-1:0]   pc_q, pc_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                carry_q, carry_d, halted_q, halted_d;

  logic [3:0]          opc;
  logic [DATA_W-1:0]   im, alu_sum;
  logic                alu_cout, add_im;
  src_e                src;

  assign opc = ir_q[7:4];
  assign im  = ir_q[3:0];

  always_comb begin
    src    = SRC_ZERO;
    add_im = 1'b0;
    case (opc)
      OP_ADD_A:  begin src = SRC_A; add_im = 1'b1; end
      OP_ADD_B:  begin src = SRC_B; add_im = 1'b1; end
      OP_MOV_A,
      OP_MOV_B:  src = SRC_IM;
      OP_MOV_AB: src = SRC_B;
      OP_MOV_BA: src = SRC_A;
      OP_IN_A,
      OP_IN_B:   src = SRC_IN;
      default:   src = SRC_ZERO;
    endcase
  end

  td4_alu u_alu (
    .a(a_q), .b(b_q), .im(im), .in_port(in_port),
    .src(src), .add_im(add_im), .sum(alu_sum), .cout(alu_cout)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    b_d      = b_q;
    out_d    = out_q;
    ir_d     = ir_q;
    carry_d  = carry_q;
    halted_d = halted_q;
    // A halted core never leaves FETCH, so en is simply ignored from then on.
    if (en && !halted_q) begin
      if (state_q == ST_FETCH) begin
        ir_d    = rom_data;
        state_d = ST_EXEC;
      end else begin
        state_d = ST_FETCH;
        pc_d    = pc_q + 4'd1;
        carry_d = 1'b0;
        case (opc)
          OP_ADD_A:                    begin a_d = alu_sum; carry_d = alu_cout; end
          OP_ADD_B:                    begin b_d = alu_sum; carry_d = alu_cout; end
          OP_MOV_A, OP_MOV_AB, OP_IN_A: a_d = alu_sum;
          OP_MOV_B, OP_MOV_BA, OP_IN_B: b_d = alu_sum;
          OP_OUT_B:                    out_d = b_q;
          OP_OUT_IM:                   out_d = im;
          OP_JMP, OP_JNC: begin
            if (opc == OP_JMP || !carry_q) begin
              pc_d = im;
              if (im == pc_q) halted_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      ir_q     <= '0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      out_q    <= out_d;
      ir_q     <= ir_d;
      carry_q  <= carry_d;
      halted_q <= halted_d;
    end
  end

  assign rom_addr = pc_q;
  assign out_port = out_q;
  assign fetch    = (state_q == ST_FETCH);
  assign carry    = carry_q;
  assign halted   = halted_q;
endmodule

// File: tb/tb_td4_core.sv
// Instruction-level reference model compared against the core every cycle.
module tb_td4_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] rom_addr, in_port = 4'h0, out_port;
  logic [7:0] rom_data;
  logic       fetch, carry, halted;
  logic [7:0] rom [16];

  int total = 0;
  int bad = 0;

  // model state
  int  m_pc, m_a, m_b, m_out, m_c;
  bit  m_halt, m_fetch;
  logic [7:0] m_ir;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  td4_core #(.RESET_PC(4'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .rom_addr(rom_addr), .rom_data(rom_data),
    .in_port(in_port), .out_port(out_port), .fetch(fetch), .carry(carry),
    .halted(halted)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0;
    m_halt = 0; m_fetch = 1; m_ir = 8'h00;
  endtask

  task automatic m_exec(input logic [7:0] ins, input int inp);
    int im, s, nc;
    im = ins[3:0];
    nc = 0;
    case (ins[7:4])
      4'b0000: begin s = m_a + im; m_a = s % 16; nc = s / 16; end
      4'b0101: begin s = m_b + im; m_b = s % 16; nc = s / 16; end
      4'b0011: m_a = im;
      4'b0111: m_b = im;
      4'b0001: m_a = m_b;
      4'b0100: m_b = m_a;
      4'b0010: m_a = inp;
      4'b0110: m_b = inp;
      4'b1001: m_out = m_b;
      4'b1011: m_out = im;
      default: ;
    endcase
    if (ins[7:4] == 4'b1111 || (ins[7:4] == 4'b1110 && m_c == 0)) begin
      if (im == m_pc) m_halt = 1;
      m_pc = im;
    end else begin
      m_pc = (m_pc + 1) % 16;
    end
    m_c = nc;
  endtask

  // one clock: advance model from current inputs, then compare after the edge
  task automatic tick(input bit e);
    en = e;
    if (rst) m_reset();
    else if (e && !m_halt) begin
      if (m_fetch) begin m_ir = rom[m_pc]; m_fetch = 0; end
      else begin m_exec(m_ir, in_port); m_fetch = 1; end
    end
    @(posedge clk);
    #1;
    chk("pc", 8'(rom_addr), 8'(m_pc));
    chk("a", 8'(dut.a_q), 8'(m_a));
    chk("b", 8'(dut.b_q), 8'(m_b));
    chk("out", 8'(out_port), 8'(m_out));
    chk("carry", 8'(carry), 8'(m_c));
    chk("fetch", 8'(fetch), 8'(m_fetch));
    chk("halted", 8'(halted), 8'(m_halt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b1);
    tick(1'b1);
    rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  initial begin
    clear_rom();
    // reset, then hold with en low
    do_reset();
    chk("rst_pc", 8'(rom_addr), 8'h0);
    chk("rst_fetch", 8'(fetch), 8'h1);
    for (int i = 0; i < 5; i++) tick(1'b0);

    // arithmetic and carry
    rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE0; rom[3] = 8'h01;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1);
    chk("add_a", 8'(dut.a_q), 8'h1);
    chk("add_carry", 8'(carry), 8'h1);
    for (int i = 0; i < 4; i++) tick(1'b1);
    chk("jnc_not_taken_pc", 8'(rom_addr), 8'h4);
    chk("mov_ab_carry", 8'(carry), 8'h0);

    // I/O path, in_port wiggles while fetching IN B
    clear_rom();
    rom[0] = 8'h60; rom[1] = 8'h90; rom[2] = 8'hB5;
    do_reset();
    in_port = 4'h3; tick(1'b1);
    in_port = 4'hA; tick(1'b1);
    in_port = 4'h7; tick(1'b1); tick(1'b1);
    chk("out_b", 8'(out_port), 8'hA);
    tick(1'b1); tick(1'b1);
    chk("out_im", 8'(out_port), 8'h5);

    // PC wrap on all-zero ROM
    clear_rom();
    do_reset();
    for (int i = 0; i < 34; i++) tick(1'b1);
    chk("wrap_pc", 8'(rom_addr), 8'h1);

    // halt
    rom[0] = 8'h72; rom[1] = 8'hF1;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1);
    chk("halt_set", 8'(halted), 8'h1);
    for (int i = 0; i < 20; i++) tick(i[0]);
    chk("halt_pc", 8'(rom_addr), 8'h1);
    do_reset();
    chk("halt_clr", 8'(halted), 8'h0);

    // reset during EXEC of MOV A,15
    clear_rom();
    rom[0] = 8'h3F;
    do_reset();
    tick(1'b1);
    rst = 1'b1; tick(1'b1); rst = 1'b0;
    chk("midrst_a", 8'(dut.a_q), 8'h0);
    tick(1'b1); tick(1'b1);
    chk("midrst_a2", 8'(dut.a_q), 8'hF);

    // randomized programs
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      do_reset();
      for (int c = 0; c < 80; c++) begin
        in_port = 4'($urandom);
        if ($urandom_range(0, 19) == 0) begin
          rst = 1'b1; tick(1'b1); rst = 1'b0;
        end else begin
          tick($urandom_range(0, 3) != 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
